babbage_bcd: RTL and testbench

- Downstream stage of the difference-engine block. Takes its 8-bit result f and converts it to packed BCD for the seven-segment display driver.
- Sequential shift-add-3 (double-dabble) converter with a start/done_tick handshake that mirrors the engine's own interface.
- The engine's done_tick is wired directly to this block's start; its f is wired to bin.

---
 rtl/babbage_bcd.sv | 118 +++++++++++
 tb/tb_babbage_bcd.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/babbage_bcd.sv
// babbage_bcd: sequential shift-add-3 (double-dabble) binary to packed BCD
// converter. Sits behind the difference engine; the engine's done_tick drives
// start and its f result drives bin. The start/done_tick handshake matches the
// engine's own interface.
//
// DIGITS must satisfy 10^DIGITS > 2^WIDTH - 1. That guarantees the carry out
// of the top working digit is always zero, so no result can overflow.
module babbage_bcd #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  ready,
  output logic                  done_tick,
  output logic [4*DIGITS-1:0]   bcd
);

  // The counter needs to hold the value WIDTH, so it gets one extra code.
  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    shiftReg_q, shiftReg_d;
  logic [BW-1:0]       digits_q, digits_d;
  logic [CW-1:0]       count_q, count_d;
  logic [BW-1:0]       bcd_q, bcd_d;

  logic [BW-1:0]       adjusted;
  logic [BW+WIDTH-1:0] shifted;

  // Add 3 to every working digit that is 5 or more, before the shift.
  // A digit is at most 9 at this point, so the sum fits in 4 bits.
  always_comb begin
    adjusted = digits_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (digits_q[4*k +: 4] >= 4'd5) begin
        adjusted[4*k +: 4] = digits_q[4*k +: 4] + 4'd3;
      end
    end
  end

  // One double-dabble step: shift {digits, shift register} left by one.
  // The shift register MSB moves into bit 0 of digit 0.
  assign shifted = {adjusted, shiftReg_q} << 1;

  // Next-state logic for the FSM and the datapath registers.
  always_comb begin
    state_d    = state_q;
    shiftReg_d = shiftReg_q;
    digits_d   = digits_q;
    count_d    = count_q;
    bcd_d      = bcd_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          shiftReg_d = bin;
          digits_d   = '0;
          count_d    = CW'(WIDTH);
          state_d    = OP;
        end
      end

      OP: begin
        digits_d   = shifted[BW+WIDTH-1:WIDTH];
        shiftReg_d = shifted[WIDTH-1:0];
        count_d    = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          // The last step publishes the digits. The visible result never
          // shows a partial conversion.
          bcd_d   = shifted[BW+WIDTH-1:WIDTH];
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. An asynchronous active-low reset aborts any
  // conversion in progress and clears the published result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      shiftReg_q <= '0;
      digits_q   <= '0;
      count_q    <= '0;
      bcd_q      <= '0;
    end else begin
      state_q    <= state_d;
      shiftReg_q <= shiftReg_d;
      digits_q   <= digits_d;
      count_q    <= count_d;
      bcd_q      <= bcd_d;
    end
  end

  // Moore outputs decoded from the registered state.
  assign ready     = (state_q == IDLE);
  assign done_tick = (state_q == DONE);
  assign bcd       = bcd_q;

endmodule

// File: tb/tb_babbage_bcd.sv
// Testbench for babbage_bcd. Directed and random conversions are compared
// against a decimal reference computed with division and modulo. The bench
// also checks handshake timing, busy-start rejection, and mid-conversion
// reset.
module tb_babbage_bcd;

   logic        clk;
   logic        resetN;
   logic        start;
   logic [7:0]  bin;
   logic        ready;
   logic        doneTick;
   logic [11:0] bcd;

   int checks;
   int failures;

   babbage_bcd #(
      .WIDTH (8),
      .DIGITS(3)
   ) dut (
      .clk      (clk),
      .reset    (resetN),
      .start    (start),
      .bin      (bin),
      .ready    (ready),
      .done_tick(doneTick),
      .bcd      (bcd)
   );

   // Free-running clock with a 10-time-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: the decimal digits of v, one per nibble, hundreds on top.
   function automatic logic [11:0] bcdModel(input int v);
      return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   // Difference-engine output for step i: f(i) = 2i^2 + 3i + 5.
   function automatic int engineF(input int i);
      return 2 * i * i + 3 * i + 5;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Run one conversion of v from IDLE and check its latency and result.
   // Also check that bcd holds still until done_tick and that done_tick
   // lasts exactly one cycle. bin is scrambled after acceptance.
   task automatic applyStimulus(input logic [7:0] v, input string tag);
      int          cycles;
      logic [11:0] prevBcd;
      logic        stableOk;
      @(negedge clk);
      checkOutput({tag, "_ready_before"}, 32'(ready), 32'd1);
      prevBcd = bcd;
      bin     = v;
      start   = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      bin      = 8'($urandom);
      cycles   = 1;
      stableOk = 1'b1;
      checkOutput({tag, "_busy"}, 32'(ready), 32'd0);
      while (!doneTick && cycles < 50) begin
         if (bcd !== prevBcd) stableOk = 1'b0;
         @(negedge clk);
         cycles++;
      end
      checkOutput({tag, "_latency"}, 32'(cycles), 32'd9);
      checkOutput({tag, "_stable"}, 32'(stableOk), 32'd1);
      checkOutput({tag, "_bcd"}, 32'(bcd), 32'(bcdModel(int'(v))));
      @(negedge clk);
      checkOutput({tag, "_pulse_end"}, 32'(doneTick), 32'd0);
      checkOutput({tag, "_ready_after"}, 32'(ready), 32'd1);
      checkOutput({tag, "_bcd_held"}, 32'(bcd), 32'(bcdModel(int'(v))));
   endtask

   initial begin
      int          cycles;
      int          pulses;
      int          lastDone;
      logic        okFlag;
      logic [7:0]  rv;

      checks   = 0;
      failures = 0;
      resetN   = 1'b0;
      start    = 1'b0;
      bin      = 8'd0;

      // Check the outputs while reset is held, then release it.
      repeat (2) @(negedge clk);
      checkOutput("reset_ready", 32'(ready), 32'd1);
      checkOutput("reset_done", 32'(doneTick), 32'd0);
      checkOutput("reset_bcd", 32'(bcd), 32'd0);
      resetN = 1'b1;
      @(negedge clk);
      checkOutput("idle_ready", 32'(ready), 32'd1);

      // Directed boundary values.
      applyStimulus(8'd0, "zero");
      applyStimulus(8'd255, "max");
      applyStimulus(8'd99, "v99");
      applyStimulus(8'd100, "v100");

      // Chained behind the engine: f = 5, 10, 19, 32.
      for (int i = 0; i < 4; i++) applyStimulus(8'(engineF(i)), "engine");

      // Start requests arriving in OP and in DONE must be ignored.
      @(negedge clk);
      bin   = 8'd42;
      start = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      bin    = 8'd200;
      cycles = 1;
      repeat (2) @(negedge clk);
      cycles += 2;
      start = 1'b1;
      @(negedge clk);
      cycles++;
      start = 1'b0;
      while (!doneTick && cycles < 50) begin
         @(negedge clk);
         cycles++;
      end
      checkOutput("busy_latency", 32'(cycles), 32'd9);
      checkOutput("busy_bcd", 32'(bcd), 32'h042);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput("busy_ready", 32'(ready), 32'd1);
      okFlag = 1'b1;
      repeat (12) begin
         @(negedge clk);
         if (doneTick !== 1'b0 || ready !== 1'b1 || bcd !== 12'h042)
            okFlag = 1'b0;
      end
      checkOutput("busy_ignored", 32'(okFlag), 32'd1);

      // Reset four cycles into a conversion aborts it immediately.
      @(negedge clk);
      bin   = 8'd123;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      resetN = 1'b0;
      #1;
      checkOutput("abort_ready", 32'(ready), 32'd1);
      checkOutput("abort_bcd", 32'(bcd), 32'd0);
      checkOutput("abort_done", 32'(doneTick), 32'd0);
      @(negedge clk);
      resetN = 1'b1;
      okFlag = 1'b1;
      repeat (12) begin
         @(negedge clk);
         if (doneTick !== 1'b0 || bcd !== 12'h000) okFlag = 1'b0;
      end
      checkOutput("abort_no_pulse", 32'(okFlag), 32'd1);
      applyStimulus(8'd77, "after_abort");

      // Holding start high repeats the conversion every 10 cycles.
      @(negedge clk);
      bin      = 8'd17;
      start    = 1'b1;
      pulses   = 0;
      lastDone = -1;
      okFlag   = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (doneTick) begin
            pulses++;
            checkOutput("hold_bcd", 32'(bcd), 32'h017);
            if (lastDone >= 0) checkOutput("hold_period", 32'(c - lastDone), 32'd10);
            lastDone = c;
         end else if (pulses > 0 && bcd !== 12'h017) begin
            okFlag = 1'b0;
         end
      end
      start = 1'b0;
      checkOutput("hold_pulses", 32'(pulses), 32'd4);
      checkOutput("hold_stable", 32'(okFlag), 32'd1);

      // Random values against the decimal reference.
      for (int n = 0; n < 20; n++) begin
         rv = 8'($urandom_range(255, 0));
         applyStimulus(rv, "random");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
